// File: rtl/datapath_pkg.sv
// Shared datapath types: occupancy states for pipelined select stages,
// writeback-source select encodings, and the selector fan-in limit.
package datapath_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam int unsigned MUXN_MAX_N = 16;

endpackage

// File: rtl/muxn_comb.sv
// Combinational N-way WIDTH-bit selector; any select value without a
// matching input falls back to input 0.
module muxn_comb #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 3,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = d[0 +: WIDTH];
    for (int unsigned i = 1; i < N; i++) begin
      if (sel == SEL_W'(i)) y = d[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// Pipelined N-way select stage with valid/ready handshake and a 2-entry skid
// buffer. Define MUXN_SEL_CHECK_EN to build the sticky out-of-range sel_err flag.
module muxn_pipe
  import datapath_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 3,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               sel_err
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [WIDTH-1:0] sel_value;
  logic             in_xfer, out_xfer;

  muxn_comb #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .d   (d),
    .sel (sel),
    .y   (sel_value)
  );

  // in_ready is a function of occupancy only, so no combinational path from out_ready
  assign in_ready  = rst_n && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign y         = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = sel_value;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = sel_value;
        end else if (in_xfer) begin
          skid_d  = sel_value;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUXN_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;
  logic sel_oor;

  assign sel_oor = (32'(sel) >= N);

  always_comb begin
    sel_err_d = sel_err_q || (in_xfer && sel_oor);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && in_xfer)
      assert (!sel_oor)
      else $warning("muxn_pipe: out-of-range select %0d accepted (N=%0d)", sel, N);
  end
`endif
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: the driver pushes hand-computed expected
// values on each input transfer, a negedge monitor pops and compares outputs.
module tb_muxn_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 3;
  localparam int unsigned SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] d;
  logic [SEL_W-1:0]   sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               sel_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pops   = 0;
  int unsigned stalls = 0;
  logic [WIDTH-1:0] exp_q[$];

  muxn_pipe #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one transfer and holds it until accepted (bounded).
  task automatic send(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] exp);
    bit done = 0;
    in_valid = 1'b1;
    sel      = s;
    for (int unsigned k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1;
      end else begin
        stalls++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for sel=%0d", s);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", y);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        pops++;
        if (y !== e) begin
          errors++;
          $display("FAIL scoreboard_y: got %h expected %h", y, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] base [3];
    int unsigned p0;
    base[0] = 32'hA; base[1] = 32'hB; base[2] = 32'hC;

    // Reset held with in_valid high
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    out_ready = 1'b1;
    d         = {32'hC, 32'hB, 32'hA};
    repeat (3) tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y",         y,                  32'd0);
    check("rst_sel_err",   {31'd0, sel_err},   32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Basic select with 1-cycle latency
    send(2'd1, 32'hB);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("basic_y_b", y, 32'hB);
    send(2'd2, 32'hC);
    check("basic_y_c", y, 32'hC);
    tick();
    check("basic_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    send(2'd0, 32'hA);
    send(2'd2, 32'hC);
    check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_y_held",    y,                  32'hA);
    repeat (3) tick();
    check("bp_y_stable",  y,                  32'hA);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_first", y, 32'hA);
    tick();
    check("bp_drain_second", y, 32'hC);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming with per-transfer data so ordering is visible
    p0     = pops;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      d = {32'hC + 32'(i), 32'hB + 32'(i), 32'hA + 32'(i)};
      send(SEL_W'(i % 3), base[i % 3] + 32'(i));
    end
    check("stream_last_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_outputs", 32'(pops - p0), 32'd100);
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Out-of-range select falls back to d[0]
    d = {32'hC, 32'hB, 32'hA};
    send(2'd3, 32'hA);
    check("oor_y", y, 32'hA);
`ifdef MUXN_SEL_CHECK_EN
    check("oor_sel_err", {31'd0, sel_err}, 32'd1);
    repeat (2) tick();
    check("oor_sel_err_sticky", {31'd0, sel_err}, 32'd1);
`else
    check("oor_sel_err", {31'd0, sel_err}, 32'd0);
    repeat (2) tick();
    check("oor_sel_err_sticky", {31'd0, sel_err}, 32'd0);
`endif

    // Reset while two entries are buffered
    out_ready = 1'b0;
    send(2'd1, 32'hB);
    send(2'd2, 32'hC);
    check("mid_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sel_err", {31'd0, sel_err}, 32'd0);
    exp_q.delete();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    p0 = pops;
    send(2'd0, 32'hA);
    check("mid_new_y", y, 32'hA);
    repeat (3) tick();
    check("mid_single_output", 32'(pops - p0), 32'd1);
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way, WIDTH-bit select stage with a valid/ready handshake and a registered output.
- A 2-entry skid buffer gives 1-cycle latency and full throughput under backpressure.
- Replaces fixed 3-input combinational selectors on datapath select points: writeback source, ALU operand B, next-PC.
- Usable wherever a select point is pipelined.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 3, number of data inputs; legal range 2..16.
- SEL_W, $clog2(N), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream presents d/sel this cycle.
- in_ready  output  1  stage accepts a transfer this cycle.
- d  input  N*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary select, sampled with in_valid.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  downstream accepts y this cycle.
- y  output  WIDTH  selected data.
- sel_err  output  1  sticky out-of-range-select flag; see Optional Feature.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low. Sampled on the clk rising edge with rst_n=0:
  - state=EMPTY, out_valid=0, y=0, skid register=0, sel_err=0.
  - in_ready=0 while rst_n=0; in_valid is ignored.
  - Reset mid-operation discards all buffered data; no partial transfer is emitted.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Selection, applied at capture time:
  - sel < N: value = d[sel].
  - sel >= N: value = d[0].
  - Capture is pure bit-select; no arithmetic and no sign extension.
- State machine (EMPTY, ONE, TWO); main register drives y, skid register holds overflow:
  - EMPTY: out_valid=0, in_ready=1. On input transfer, main <= value, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together: main <= value, stay in ONE.
    - Input transfer only: skid <= value, go to TWO.
    - Output transfer only: go to EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer: main <= skid, go to ONE.
  - in_ready depends only on state and rst_n, never combinationally on out_ready.
- Timing: latency is exactly 1 cycle from input transfer to out_valid when EMPTY. Sustained throughput is 1 per cycle with out_ready held high.
- Output stability: y and out_valid are stable while out_valid=1 and out_ready=0.
- Ordering: FIFO; no reordering or dropping. Maximum occupancy is 2.

Optional Feature:
- Macro: MUXN_SEL_CHECK_EN.
- Defined:
  - Any input transfer with sel >= N sets sel_err on the next edge.
  - sel_err holds until reset.
  - Data behaviour is unchanged (d[0] is selected).
  - A simulation-only assertion fires on the offending transfer.
- Undefined: sel_err is tied to 0 and no check logic is built.
- When N is a power of two, sel >= N is impossible, so sel_err stays 0 in both builds.

Decomposition:
- Shared package datapath_pkg holds:
  - Occupancy state enum (EMPTY, ONE, TWO).
  - Writeback-select encodings (WB_ALU=0, WB_MEM=1, WB_PC4=2) consumed by callers.
  - Constant MUXN_MAX_N=16.
- One sub-module, muxn_comb: parametrised combinational N-way selector with out-of-range default to d[0]. Instantiated once, ahead of the capture registers.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, y=0. Release rst_n -> in_ready=1 on the first cycle after release.
2. Basic select: N=3, WIDTH=32, d={32'hC,32'hB,32'hA} (index 2,1,0), sel=1, out_ready=1, one transfer -> next cycle out_valid=1, y=32'hB. Then sel=2 -> y=32'hC.
3. Backpressure, out_ready=0: two transfers with sel=0 then sel=2 -> state TWO, in_ready=0, y=32'hA held stable. Raise out_ready -> y=32'hA then 32'hC on consecutive cycles, then out_valid=0.
4. Streaming: 100 back-to-back transfers, sel cycling 0,1,2, out_ready=1 throughout -> 100 outputs, one per cycle, in order, in_ready never drops.
5. Out-of-range: sel=3 with N=3 -> y=d[0]. With MUXN_SEL_CHECK_EN, sel_err=1 from the next cycle until reset. Without the macro, sel_err=0.
6. Reset mid-operation: in state TWO, assert rst_n=0 for one cycle -> out_valid=0, buffered entries lost. After release, the first new transfer emerges alone.
